// File: rtl/vc_scheduler.sv
// Read-side scheduler for two virtual-channel FIFOs: weighted VC0/VC1 read
// arbitration, class-bit routing to two destination FIFOs, and a config/error FSM.
module vc_scheduler #(
  parameter int data_width  = 6,
  parameter int prio_weight = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic [3:0]            umbral_vc_in,
  input  logic [3:0]            umbral_d_in,
  input  logic                  empty_vc0,
  input  logic                  empty_vc1,
  input  logic                  error_vc0,
  input  logic                  error_vc1,
  input  logic [data_width-1:0] data_vc0,
  input  logic [data_width-1:0] data_vc1,
  input  logic                  full_d0,
  input  logic                  full_d1,
  input  logic                  almost_full_d0,
  input  logic                  almost_full_d1,
  output logic                  rd_vc0,
  output logic                  rd_vc1,
  output logic [3:0]            umbral_vc,
  output logic [3:0]            umbral_d,
  output logic                  wr_d0,
  output logic                  wr_d1,
  output logic [data_width-1:0] data_d,
  output logic [2:0]            state,
  output logic                  idle,
  output logic                  error_out
);

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  localparam logic [2:0] PW = 3'(prio_weight);

  state_t                st, st_nxt;
  logic [2:0]            weight_cnt;
  logic                  vld_pipe;   // a read word arrives on data_vc* this cycle
  logic                  src_tag;    // 1: arriving word came from VC1
  logic                  stall, err_now, rd_ok, drop;
  logic [data_width-1:0] word;

  assign state   = st;
  assign stall   = full_d0 | full_d1 | almost_full_d0 | almost_full_d1;
  assign err_now = (st != ST_RESET) &&
                   (error_vc0 | error_vc1 | (wr_d0 & full_d0) | (wr_d1 & full_d1));
  assign rd_ok   = (st == ST_ACTIVE) && !stall && !err_now;
  assign drop    = err_now || (st == ST_ERROR);
  assign word    = src_tag ? data_vc1 : data_vc0;

  // Mealy read enables so a read never outruns the FIFO's current empty flag
  always_comb begin
    rd_vc0 = 1'b0;
    rd_vc1 = 1'b0;
    if (rd_ok) begin
      if (!empty_vc0 && !empty_vc1) begin
        if (weight_cnt == PW) rd_vc1 = 1'b1;
        else                  rd_vc0 = 1'b1;
      end else if (!empty_vc0) begin
        rd_vc0 = 1'b1;
      end else if (!empty_vc1) begin
        rd_vc1 = 1'b1;
      end
    end
  end

  always_comb begin
    st_nxt = st;
    case (st)
      ST_RESET:  st_nxt = ST_INIT;
      ST_INIT:   if (err_now) st_nxt = ST_ERROR;
                 else if (!init) st_nxt = ST_IDLE;
      ST_IDLE:   if (err_now) st_nxt = ST_ERROR;
                 else if (init) st_nxt = ST_INIT;
                 else if (!empty_vc0 || !empty_vc1) st_nxt = ST_ACTIVE;
      ST_ACTIVE: if (err_now) st_nxt = ST_ERROR;
                 else if (init) st_nxt = ST_INIT;
                 else if (empty_vc0 && empty_vc1 && !vld_pipe) st_nxt = ST_IDLE;
      ST_ERROR:  st_nxt = ST_ERROR;
      default:   st_nxt = ST_RESET;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st         <= ST_RESET;
      idle       <= 1'b0;
      error_out  <= 1'b0;
      umbral_vc  <= '0;
      umbral_d   <= '0;
      weight_cnt <= '0;
      vld_pipe   <= 1'b0;
      src_tag    <= 1'b0;
      wr_d0      <= 1'b0;
      wr_d1      <= 1'b0;
      data_d     <= '0;
    end else begin
      st        <= st_nxt;
      idle      <= (st_nxt == ST_IDLE);
      error_out <= (st_nxt == ST_ERROR);
      if (st == ST_INIT) begin
        umbral_vc <= umbral_vc_in;
        umbral_d  <= umbral_d_in;
      end
      // VC0 streak only counts while VC1 is actually waiting
      if (rd_vc1)
        weight_cnt <= '0;
      else if (rd_vc0 && !empty_vc1 && weight_cnt != PW)
        weight_cnt <= weight_cnt + 3'd1;
      vld_pipe <= (rd_vc0 | rd_vc1) && !drop;
      src_tag  <= rd_vc1;
      if (vld_pipe && !drop) begin
        wr_d0  <= ~word[data_width-1];
        wr_d1  <=  word[data_width-1];
        data_d <=  word;
      end else begin
        wr_d0  <= 1'b0;
        wr_d1  <= 1'b0;
        data_d <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vc_scheduler.sv
// Directed bench for vc_scheduler: table-driven config/single-VC sequence plus
// hand-written arbitration, stall, error and mid-transfer reset sequences.
module tb_vc_scheduler;
  localparam int DW = 6;
  localparam int PW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          init = 1'b0;
  logic [3:0]    umbral_vc_in = 4'd1, umbral_d_in = 4'd2;
  logic          empty_vc0 = 1'b1, empty_vc1 = 1'b1;
  logic          error_vc0 = 1'b0, error_vc1 = 1'b0;
  logic [DW-1:0] data_vc0 = '0, data_vc1 = '0;
  logic          full_d0 = 1'b0, full_d1 = 1'b0;
  logic          almost_full_d0 = 1'b0, almost_full_d1 = 1'b0;
  logic          rd_vc0, rd_vc1, wr_d0, wr_d1, idle, error_out;
  logic [3:0]    umbral_vc, umbral_d;
  logic [DW-1:0] data_d;
  logic [2:0]    state;

  vc_scheduler #(.data_width(DW), .prio_weight(PW)) dut (
    .clk(clk), .reset(reset), .init(init),
    .umbral_vc_in(umbral_vc_in), .umbral_d_in(umbral_d_in),
    .empty_vc0(empty_vc0), .empty_vc1(empty_vc1),
    .error_vc0(error_vc0), .error_vc1(error_vc1),
    .data_vc0(data_vc0), .data_vc1(data_vc1),
    .full_d0(full_d0), .full_d1(full_d1),
    .almost_full_d0(almost_full_d0), .almost_full_d1(almost_full_d1),
    .rd_vc0(rd_vc0), .rd_vc1(rd_vc1),
    .umbral_vc(umbral_vc), .umbral_d(umbral_d),
    .wr_d0(wr_d0), .wr_d1(wr_d1), .data_d(data_d),
    .state(state), .idle(idle), .error_out(error_out)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int nwr = 0;
  logic [DW-1:0] q0[$], q1[$], sb[$];
  int grants[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic upd();
    empty_vc0 = (q0.size() == 0);
    empty_vc1 = (q1.size() == 0);
  endtask

  // One clock of the VC FIFO model: sample Mealy reads, score writes, return data next cycle
  task automatic cyc(output logic r0, output logic r1, output logic w);
    logic [DW-1:0] e;
    @(negedge clk);
    r0 = rd_vc0;
    r1 = rd_vc1;
    w  = wr_d0 | wr_d1;
    if (r0 && r1) chk("rd_onehot", {r1, r0}, 2'b01);
    if (r0) grants.push_back(0);
    if (r1) grants.push_back(1);
    if (w) begin
      nwr++;
      if (sb.size() == 0) begin
        chk("unexpected_wr", {wr_d1, wr_d0}, 2'b00);
      end else begin
        e = sb.pop_front();
        chk("wr_dest", {wr_d1, wr_d0}, e[DW-1] ? 2'b10 : 2'b01);
        chk("data_d", data_d, e);
      end
    end
    @(posedge clk); #1;
    data_vc0 = '0;
    data_vc1 = '0;
    if (r0 && q0.size() > 0) begin data_vc0 = q0.pop_front(); sb.push_back(data_vc0); end
    if (r1 && q1.size() > 0) begin data_vc1 = q1.pop_front(); sb.push_back(data_vc1); end
    upd();
  endtask

  task automatic do_init();
    logic a, b, c;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    init = 1'b1;
    cyc(a, b, c);
    cyc(a, b, c);
    init = 1'b0;
    cyc(a, b, c);
    chk("init_to_idle", state, 3'd2);
  endtask

  typedef struct {
    logic init, e0, e1;
    logic [DW-1:0] d0;
    logic [2:0] st;
    logic rd0, rd1, wr0, wr1;
    logic [DW-1:0] dd;
    logic idl;
    logic [3:0] uvc, ud;
  } vec_t;

  vec_t tbl[9];

  initial begin
    logic r0, r1, w;
    int exp_g[16];
    int stall_wr, base, cnt;

    //            init  e0    e1    d0      st    rd0   rd1   wr0   wr1   dd      idle  uvc   ud
    tbl[0] = '{1'b1, 1'b1, 1'b1, 6'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 4'd0, 4'd0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 6'h00, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 4'd0, 4'd0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 6'h00, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 4'd1, 4'd2};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 6'h00, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 1'b1, 4'd1, 4'd2};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 6'h00, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 4'd1, 4'd2};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 6'h05, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 4'd1, 4'd2};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 6'h21, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 6'h05, 1'b0, 4'd1, 4'd2};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 6'h00, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 6'h21, 1'b0, 4'd1, 4'd2};
    tbl[8] = '{1'b0, 1'b1, 1'b1, 6'h00, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 1'b1, 4'd1, 4'd2};

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst state", state, 3'd0);
    chk("rst rd", {rd_vc1, rd_vc0}, 2'b00);
    chk("rst wr", {wr_d1, wr_d0}, 2'b00);
    chk("rst data_d", data_d, 6'h00);
    chk("rst umbral", {umbral_vc, umbral_d}, 8'h00);
    chk("rst flags", {idle, error_out}, 2'b00);
    @(posedge clk); #1;
    reset = 1'b0;

    // config + single-VC two-word stream
    for (int i = 0; i < 9; i++) begin
      init = tbl[i].init;
      empty_vc0 = tbl[i].e0;
      empty_vc1 = tbl[i].e1;
      data_vc0 = tbl[i].d0;
      @(negedge clk);
      chk($sformatf("t%0d state", i), state, tbl[i].st);
      chk($sformatf("t%0d rd_vc0", i), rd_vc0, tbl[i].rd0);
      chk($sformatf("t%0d rd_vc1", i), rd_vc1, tbl[i].rd1);
      chk($sformatf("t%0d wr_d0", i), wr_d0, tbl[i].wr0);
      chk($sformatf("t%0d wr_d1", i), wr_d1, tbl[i].wr1);
      if (tbl[i].wr0 || tbl[i].wr1) chk($sformatf("t%0d data_d", i), data_d, tbl[i].dd);
      chk($sformatf("t%0d idle", i), idle, tbl[i].idl);
      chk($sformatf("t%0d umbral_vc", i), umbral_vc, tbl[i].uvc);
      chk($sformatf("t%0d umbral_d", i), umbral_d, tbl[i].ud);
      @(posedge clk); #1;
    end
    data_vc0 = '0;
    upd();

    // weighted arbitration, both VCs holding 8 words
    for (int i = 0; i < 8; i++) begin
      q0.push_back(6'((i % 2) << 5 | i));
      q1.push_back(6'((i % 2) << 5 | (8 + i)));
    end
    upd();
    exp_g = '{0,0,0,1, 0,0,0,1, 0,0,1,1, 1,1,1,1};
    grants.delete();
    nwr = 0;
    cnt = 0;
    while (grants.size() < 16 && cnt < 60) begin cyc(r0, r1, w); cnt++; end
    chk("arb budget", cnt < 60, 1);
    repeat (4) cyc(r0, r1, w);
    for (int i = 0; i < 16; i++)
      chk($sformatf("grant%0d", i), (i < grants.size()) ? grants[i] : -1, exp_g[i]);
    chk("arb writes", nwr, 16);
    chk("arb sb empty", sb.size(), 0);
    @(negedge clk);
    chk("arb back to idle", state, 3'd2);
    @(posedge clk); #1;

    // almost_full_d1 stall mid-stream
    for (int i = 0; i < 6; i++) q0.push_back(6'((i % 2) << 5 | (16 + i)));
    upd();
    nwr = 0;
    stall_wr = 0;
    for (int c = 0; c < 12; c++) begin
      almost_full_d1 = (c >= 3 && c < 6);
      cyc(r0, r1, w);
      if (c >= 3 && c < 6) begin
        chk($sformatf("stall c%0d rd", c), {r1, r0}, 2'b00);
        if (w) stall_wr++;
      end
      if (c == 6) chk("resume rd", r0, 1);
    end
    almost_full_d1 = 1'b0;
    chk("stall inflight writes", stall_wr, 2);
    chk("stall total writes", nwr, 6);
    chk("stall sb empty", sb.size(), 0);

    // error_vc1 in ACTIVE is sticky
    for (int i = 0; i < 4; i++) begin
      q0.push_back(6'(24 + i));
      q1.push_back(6'(6'h20 | (28 + i)));
    end
    upd();
    repeat (3) cyc(r0, r1, w);
    chk("pre-err active", state, 3'd3);
    error_vc1 = 1'b1;
    cyc(r0, r1, w);
    error_vc1 = 1'b0;
    @(negedge clk);
    chk("err state", state, 3'd4);
    chk("err error_out", error_out, 1);
    @(posedge clk); #1;
    base = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (rd_vc0 | rd_vc1 | wr_d0 | wr_d1) base++;
      chk($sformatf("err sticky c%0d", c), state, 3'd4);
      @(posedge clk); #1;
    end
    chk("err no rd/wr", base, 0);
    reset = 1'b1;
    #1;
    chk("err recover state", state, 3'd0);
    chk("err recover flag", error_out, 0);
    q0.delete(); q1.delete(); sb.delete();
    data_vc0 = '0; data_vc1 = '0;
    upd();

    // reset between a read and its write
    do_init();
    for (int i = 0; i < 3; i++) q0.push_back(6'(i + 1));
    upd();
    cnt = 0;
    r0 = 1'b0;
    while (!r0 && cnt < 10) begin cyc(r0, r1, w); cnt++; end
    chk("mid read seen", r0, 1);
    reset = 1'b1;
    #1;
    chk("mid rst state", state, 3'd0);
    chk("mid rst outs", {rd_vc0, rd_vc1, wr_d0, wr_d1, idle, error_out}, 6'b0);
    chk("mid rst data", {data_d, umbral_vc, umbral_d}, 14'h0);
    base = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (wr_d0 | wr_d1) base++;
      @(posedge clk); #1;
    end
    reset = 1'b0;
    q0.delete(); sb.delete();
    data_vc0 = '0;
    upd();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (wr_d0 | wr_d1) base++;
      @(posedge clk); #1;
    end
    chk("mid rst no wr", base, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/vc_scheduler.md
# vc_scheduler

Read-side controller for the two virtual-channel FIFOs (VC0, VC1) of the transmission layer. It configures their thresholds, arbitrates reads between them with a weighted priority, routes each popped word to one of two destination FIFOs (D0, D1) by its class bit, and applies downstream backpressure. A state machine (RESET, INIT, IDLE, ACTIVE, ERROR) sequences configuration and flags FIFO errors.

## Interface
- data_width, 6: word width of VC and destination FIFOs.
- prio_weight, 3: consecutive VC0 grants allowed while VC1 waits before VC1 is forced; range 1..7.

- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- init  in  1  request configuration; held high while in INIT.
- umbral_vc_in  in  4  threshold value for the VC FIFOs, captured in INIT.
- umbral_d_in  in  4  threshold value for the destination FIFOs, captured in INIT.
- empty_vc0, empty_vc1  in  1  VC FIFO empty flags.
- error_vc0, error_vc1  in  1  VC FIFO error flags.
- data_vc0, data_vc1  in  data_width  VC FIFO registered read data; valid the cycle after a read, 0 otherwise.
- full_d0, full_d1, almost_full_d0, almost_full_d1  in  1  destination FIFO flags.
- rd_vc0, rd_vc1  out  1  VC FIFO read enables (combinational, at most one high).
- umbral_vc, umbral_d  out  4  configured thresholds driven to the FIFOs.
- wr_d0, wr_d1  out  1  destination write enables (registered).
- data_d  out  data_width  destination write data (registered).
- state  out  3  RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4.
- idle  out  1  high in IDLE.
- error_out  out  1  high in ERROR.

## Operation
- RESET -> INIT on the first edge after reset deasserts.
- INIT: umbral_vc/umbral_d load from the *_in ports every edge; no reads. INIT -> IDLE when init=0.
- IDLE: -> ACTIVE when either VC is non-empty; no reads in IDLE.
- ACTIVE: reads issued per arbitration. -> IDLE when both VCs are empty and no word is in flight.
- IDLE/ACTIVE -> INIT when init=1. In-flight words still complete their writes.
- Any state except RESET -> ERROR when error_vc0, error_vc1, or a destination write occurs while that destination is full. ERROR is sticky until reset, with no reads. In-flight words are dropped.
- Stall: no read in any cycle where any of full_d0, full_d1, almost_full_d0 or almost_full_d1 is high.
- Arbitration, in ACTIVE and not stalled:
  - Only one VC non-empty: read that VC.
  - Both non-empty: read VC0 unless weight_cnt == prio_weight, then read VC1.
- weight_cnt (3 bits): cleared on every VC1 grant. Incremented, saturating at prio_weight, on a VC0 grant while VC1 is non-empty. Unchanged otherwise.
- Routing: the word arriving the cycle after a read goes to D0 if data[data_width-1]=0, else D1. Only the destination write enable is asserted.

## Timing
- Reset values: state=0, rd_vc*=0, wr_d*=0, data_d=0, umbral_vc=0, umbral_d=0, idle=0, error_out=0, weight_cnt=0, pipeline valid=0.
- rd_vc* are Mealy outputs: they react to the current cycle's empty and full flags, so reads never exceed the FIFO count.
- Pipeline latency is 2 cycles:
  - rd in cycle n;
  - data_vc valid in cycle n+1, captured with its source tag;
  - wr_d*/data_d high in cycle n+2 for exactly one cycle.
- Back-to-back reads are allowed, sustaining 1 word/cycle.
- At most 2 words are in flight, so umbral_d must be at least 2.
- Asserting reset mid-transfer clears outputs asynchronously and loses in-flight words.

## Test plan
- Reset, then init=1 with umbral_vc_in=1 and umbral_d_in=2, then init=0: state goes 0->1->2 and umbral_vc=1, umbral_d=2.
- VC0 holds 0x05 and 0x21, VC1 is empty: rd_vc0 is high for 2 cycles. wr_d0 with 0x05 appears 2 cycles after the first read, then wr_d1 with 0x21. state returns to IDLE.
- Both VCs hold 8 words, prio_weight=3: grant sequence is 0,0,0,1,0,0,0,1,…
- almost_full_d1 rises mid-stream: reads stop in the same cycle, the ≤2 in-flight writes complete, and reads resume the cycle after the flag falls.
- error_vc1 pulses in ACTIVE: state=4 and error_out=1 the next cycle, with no further reads. Only reset recovers.
- reset asserted between a read and its write: wr_d* never asserts and all outputs are 0 immediately.
